// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake and block P/G export.
// Optional subtract mode with `sub` port is enabled by defining CLA_SUB_EN.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             p_blk,
    output logic             g_blk
);

    localparam int NG = WIDTH / GROUP;

    function automatic logic grp_prop(input logic [GROUP-1:0] p);
        return &p;
    endfunction

    // Carry out of a group assuming zero carry in.
    function automatic logic grp_gen(input logic [GROUP-1:0] p, input logic [GROUP-1:0] g);
        logic r;
        r = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            r = g[j] | (p[j] & r);
        end
        return r;
    endfunction

    logic             s1_v_q, s2_v_q;
    logic             s1_adv_s, s2_adv_s;

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] p_d, g_d, p_q, g_q;
    logic             cin_d, cin_q;
    logic [NG-1:0]    pg_d, gg_d, pg_q, gg_q;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             pblk_d, pblk_q;
    logic             gblk_d, gblk_q;

    assign s2_adv_s = !s2_v_q | out_ready;
    assign s1_adv_s = !s1_v_q | s2_adv_s;
    assign in_ready = s1_adv_s;

    // Stage-1 combinational: effective operand, bit and group propagate/generate.
    always_comb begin
`ifdef CLA_SUB_EN
        if (sub) begin
            b_eff_s = ~b;
            cin_d   = 1'b1;
        end else begin
            b_eff_s = b;
            cin_d   = cin;
        end
`else
        b_eff_s = b;
        cin_d   = cin;
`endif
        p_d  = a ^ b_eff_s;
        g_d  = a & b_eff_s;
        pg_d = '0;
        gg_d = '0;
        for (int k = 0; k < NG; k++) begin
            pg_d[k] = grp_prop(p_d[k*GROUP +: GROUP]);
            gg_d[k] = grp_gen(p_d[k*GROUP +: GROUP], g_d[k*GROUP +: GROUP]);
        end
    end

    // Stage-1 register: loads only when the stage advances with a valid beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            p_q    <= '0;
            g_q    <= '0;
            cin_q  <= 1'b0;
            pg_q   <= '0;
            gg_q   <= '0;
        end else begin
            if (s1_adv_s) begin
                s1_v_q <= in_valid;
            end
            if (s1_adv_s && in_valid) begin
                p_q   <= p_d;
                g_q   <= g_d;
                cin_q <= cin_d;
                pg_q  <= pg_d;
                gg_q  <= gg_d;
            end
        end
    end

    // Stage-2 combinational: group carry lookahead, in-group ripple, sum and flags.
    always_comb begin : s2_comb
        logic [NG:0]    cg;
        logic [WIDTH:0] c;
        logic           gb;
        cg    = '0;
        c     = '0;
        cg[0] = cin_q;
        for (int k = 0; k < NG; k++) begin
            cg[k+1] = gg_q[k] | (pg_q[k] & cg[k]);
        end
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GROUP; j++) begin
                if (j == 0) begin
                    c[k*GROUP] = cg[k];
                end else begin
                    c[k*GROUP+j] = g_q[k*GROUP+j-1] | (p_q[k*GROUP+j-1] & c[k*GROUP+j-1]);
                end
            end
        end
        c[WIDTH] = cg[NG];
        gb = 1'b0;
        for (int k = 0; k < NG; k++) begin
            gb = gg_q[k] | (pg_q[k] & gb);
        end
        sum_d  = p_q ^ c[WIDTH-1:0];
        cout_d = c[WIDTH];
        ovf_d  = c[WIDTH] ^ c[WIDTH-1];
        pblk_d = &pg_q;
        gblk_d = gb;
    end

    // Stage-2 register: results hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            pblk_q <= 1'b0;
            gblk_q <= 1'b0;
        end else begin
            if (s2_adv_s) begin
                s2_v_q <= s1_v_q;
            end
            if (s2_adv_s && s1_v_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                pblk_q <= pblk_d;
                gblk_q <= gblk_d;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign p_blk     = pblk_q;
    assign g_blk     = gblk_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed corner cases plus randomized traffic
// with random backpressure, checked against an arithmetic reference model.
module tb_pipelined_cla_adder #(
    parameter int W = 32,
    parameter int G = 4
);

    typedef logic [W+3:0] exp_t;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, cin, sub;
    logic [W-1:0] a, b, sum;
    logic         out_valid, out_ready, cout, ovf, p_blk, g_blk;
    logic         bp_en;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    logic held_v;
    exp_t held;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef CLA_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .p_blk(p_blk), .g_blk(g_blk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    // Reference: plain integer arithmetic on W+1 bits.
    function automatic exp_t model(input logic [W-1:0] ma, mb, input logic mc, ms);
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   full, gen;
        logic         ov, pb;
`ifdef CLA_SUB_EN
        bb = ms ? ~mb : mb;
        ci = ms ? 1'b1 : mc;
`else
        bb = mb;
        ci = mc;
`endif
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ci};
        gen  = {1'b0, ma} + {1'b0, bb};
        ov   = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        pb   = ((ma ^ bb) == {W{1'b1}});
        return {full[W-1:0], full[W], ov, pb, gen[W]};
    endfunction

    task automatic send(input logic [W-1:0] sa, sb, input logic sc, ss);
        int n;
        a = sa; b = sb; cin = sc; sub = ss; in_valid = 1'b1; n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            exp_q.push_back(model(sa, sb, sc, ss));
        end else begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [W-1:0] da, db, input logic dc, ds,
                            input exp_t expv);
        send(da, db, dc, ds);
        @(negedge clk);
        chk({nm, "_lat1"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk({nm, "_lat2"}, {63'd0, out_valid}, 64'd1);
        chk(nm, 64'({sum, cout, ovf, p_blk, g_blk}), 64'(expv));
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) begin
                chk("hold_stable", 64'({sum, cout, ovf, p_blk, g_blk}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got sum %0h, expected no result", sum);
                end else begin
                    chk("scoreboard", 64'({sum, cout, ovf, p_blk, g_blk}), 64'(exp_q.pop_front()));
                end
            end
            held_v = out_valid && !out_ready;
            held   = {sum, cout, ovf, p_blk, g_blk};
        end
    end

    // Random backpressure driver, active only when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb, msb, ones;
        logic         rs;
        int           n;
        ones = '1;
        msb  = {1'b1, {(W-1){1'b0}}};
        bp_en = 1'b0; out_ready = 1'b1; held_v = 1'b0;
        rst_n = 1'b0; in_valid = 1'b1; a = ones; b = ones; cin = 1'b1; sub = 1'b0;

        // Reset held with valid input asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_outputs", 64'({sum, cout, ovf, p_blk, g_blk}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_idle_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;

        directed("wrap", ones, W'(1), 1'b0, 1'b0, {{W{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b1});
        directed("ovf", ~msb, W'(0), 1'b1, 1'b0, {msb, 1'b0, 1'b1, 1'b0, 1'b0});
        directed("pblk", ones, W'(0), 1'b0, 1'b0, {ones, 1'b0, 1'b0, 1'b1, 1'b0});
`ifdef CLA_SUB_EN
        directed("sub", W'(5), W'(7), 1'b0, 1'b1, {~W'(1), 1'b0, 1'b0, 1'b0, 1'b0});
`endif

        // Backpressure: two beats fill the pipe, third waits.
        out_ready = 1'b0;
        send(W'(32'h1111), W'(32'h2222), 1'b0, 1'b0);
        send(W'(32'h3333), W'(32'h4444), 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        fork
            begin
                send(ones, ones, 1'b1, 1'b0);
                send(msb, msb, 1'b0, 1'b0);
            end
            begin
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Reset with two beats in flight: neither may emerge.
        out_ready = 1'b0;
        send(W'(32'h55), W'(32'h66), 1'b0, 1'b0);
        send(W'(32'h77), W'(32'h88), 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_no_output", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random idles and backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = ones;
                1:       ra = '0;
                default: ra = W'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       rb = ones;
                1:       rb = W'(1);
                default: rb = W'($urandom);
            endcase
`ifdef CLA_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            send(ra, rb, 1'($urandom_range(0, 1)), rs);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        bp_en = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
